// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The optional IFETCH_PERF_CNT_EN macro (see ifetch_unit) needs nothing from this package.
package ifetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Decode field positions inside an instruction word
  localparam int OPC_MSB = 6;
  localparam int OPC_LSB = 0;
  localparam int F3_MSB  = 14;
  localparam int F3_LSB  = 12;
  localparam int F7_BIT  = 30;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_buf.sv
// Synchronous FIFO of {pc, inst} fetch entries with a flush input and an occupancy count.
// Push and pop may happen in the same cycle at any occupancy; flush wins over both.
module ifetch_buf
  import ifetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_data,
  input  logic         i_pop,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Storage carries no reset: entries are only visible through a non-zero count.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC, credit-limited in-order memory reads, buffered delivery to decode.
// Define IFETCH_PERF_CNT_EN to add the perf_fetched / perf_dropped counters.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped,
`endif
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic        func7
);

  // Handshakes: a transfer happens on a cycle where valid && ready are both high at the
  // rising edge; valid never waits on ready, and a redirect cancels every transfer that cycle.

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_inflight;
  logic [31:0]   w_redirect_tgt;
  logic          w_req_fire;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;

  assign w_inflight     = {1'b0, r_outstanding} + {1'b0, w_count};
  assign w_redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  // Reset gates the request combinationally so the output is low while rst_n is held.
  assign imem_req_valid = rst_n && !redirect_valid && (w_inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp       = imem_rsp_valid && (r_outstanding != '0);
  assign w_push      = w_rsp && (r_drop == '0) && !redirect_valid;
  assign w_pop       = inst_valid && inst_ready && !redirect_valid;
  assign w_push_data = '{pc: r_rsp_pc, inst: imem_rsp_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc    <= w_redirect_tgt;
      r_rsp_pc      <= w_redirect_tgt;
      r_outstanding <= r_outstanding - CW'(w_rsp);
      r_drop        <= r_outstanding - CW'(w_rsp);
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp);
      if (w_rsp) begin
        if (r_drop != '0) r_drop   <= r_drop - CW'(1);
        else              r_rsp_pc <= r_rsp_pc + 32'd4;
      end
    end
  end

  ifetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Head fields are forced to zero when empty so outputs read 0 during and after reset.
  assign inst_valid = (w_count != '0);
  assign inst       = inst_valid ? w_head.inst : 32'h0;
  assign inst_pc    = inst_valid ? w_head.pc   : 32'h0;
  assign opcode     = inst[OPC_MSB:OPC_LSB];
  assign func3      = inst[F3_MSB:F3_LSB];
  assign func7      = inst[F7_BIT];

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_dropped;
  logic [31:0] w_drop_now;

  assign w_drop_now = 32'(w_rsp && (redirect_valid || (r_drop != '0)))
                    + (redirect_valid ? 32'(w_count) : 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_dropped <= '0;
    end else begin
      r_perf_fetched <= r_perf_fetched + 32'(w_pop);
      r_perf_dropped <= r_perf_dropped + w_drop_now;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_dropped = r_perf_dropped;
`endif

  a_rsp_protocol: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (r_outstanding != '0));
  a_credit: assert property (@(posedge clk) disable iff (!rst_n)
    w_inflight <= (CW+1)'(DEPTH));
  a_drop_le_out: assert property (@(posedge clk) disable iff (!rst_n)
    r_drop <= r_outstanding);

endmodule
